// File: rtl/spike_synapse.sv
// Excitatory synapse: rising-edge spike detect, weighted current injection, prescaled shift decay.
// Optional inhibitory input compiled in with SYN_INHIBIT_EN (adds inh_in / inh_weight ports).
module spike_synapse #(
  parameter logic [15:0] DECAY_DIV = 16'd1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spike_in,
  input  logic [7:0] weight,
  input  logic [2:0] tau_sel,
`ifdef SYN_INHIBIT_EN
  input  logic       inh_in,
  input  logic [7:0] inh_weight,
`endif
  output logic [7:0] I_syn,
  output logic       sat,
  output logic [7:0] spike_cnt
);

  localparam logic [15:0] LAST = DECAY_DIV - 16'd1;

  logic        spike_q;
  logic [15:0] pre_cnt;
  logic        spk_evt, tick, wr;
  logic [7:0]  shifted, dec, exc, nxt;
  logic [8:0]  sum;

`ifdef SYN_INHIBIT_EN
  logic inh_q;
  logic inh_evt;
  assign inh_evt = inh_in & ~inh_q & ena;
  assign wr      = tick | spk_evt | inh_evt;
`else
  assign wr      = tick | spk_evt;
`endif

  assign spk_evt = spike_in & ~spike_q & ena;
  assign tick    = (pre_cnt == LAST) & ena;

  // Decay is taken from the current value first, then the weight is added at 9 bits
  // so the carry doubles as the saturation flag.
  always_comb begin
    shifted = I_syn >> tau_sel;
    dec     = 8'd0;
    if (tick)
      dec = (shifted == 8'd0 && I_syn != 8'd0) ? 8'd1 : shifted;
    sum = {1'b0, I_syn - dec} + (spk_evt ? {1'b0, weight} : 9'd0);
    exc = sum[8] ? 8'hFF : sum[7:0];
    nxt = exc;
`ifdef SYN_INHIBIT_EN
    if (inh_evt)
      nxt = (exc > inh_weight) ? exc - inh_weight : 8'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q   <= 1'b0;
      pre_cnt   <= 16'd0;
      I_syn     <= 8'd0;
      sat       <= 1'b0;
      spike_cnt <= 8'd0;
    end else begin
      // Edge-detect history keeps tracking while disabled so no stale edge fires on re-enable.
      spike_q <= spike_in;
      if (ena) begin
        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        if (wr)
          I_syn <= nxt;
        if (tick | spk_evt)
          sat <= sum[8];
        if (spk_evt)
          spike_cnt <= spike_cnt + 8'd1;
      end
    end
  end

`ifdef SYN_INHIBIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) inh_q <= 1'b0;
    else        inh_q <= inh_in;
  end
`endif

endmodule

// File: doc/spike_synapse.md
SPIKE_SYNAPSE -- requirements
Module: spike_synapse

Interface
REQ-001 Parameter DECAY_DIV, default 16'd1000: clock cycles per decay tick; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  high = block active; low = hold all state except the edge-detect register.
REQ-005 spike_in  input  1  presynaptic spike level, synchronous to clk (driven from a QIF neuron spike output).
REQ-006 weight  input  8  unsigned excitatory weight added per spike.
REQ-007 tau_sel  input  3  decay shift amount; larger = slower decay.
REQ-008 I_syn  output  8  unsigned synaptic current, registered; drives a QIF neuron input current.
REQ-009 sat  output  1  registered; high when the most recent I_syn update clipped at 255.
REQ-010 spike_cnt  output  8  registered count of detected spikes, wraps 255->0.

Function
REQ-011 spike_q SHALL register spike_in every cycle, including when ena is low; spike event = spike_in & ~spike_q.
REQ-012 Level held high SHALL produce exactly one event; re-arm only after at least one low cycle.
REQ-013 Prescaler SHALL count 0..DECAY_DIV-1 and then wrap to 0; tick = (count == DECAY_DIV-1) & ena; DECAY_DIV=1 gives a tick every enabled cycle.
REQ-014 On tick: dec = I_syn >> tau_sel; if dec == 0 and I_syn != 0, dec = 1; otherwise dec = 0.
REQ-015 Next I_syn = min(255, (I_syn - dec) + (event ? weight : 0)), computed at 9 bits; decay applied before addition when tick and event coincide.
REQ-016 Latency: the event or tick seen at clock edge k SHALL be reflected in I_syn after edge k (one register stage).
REQ-017 sat SHALL update only on cycles where I_syn is written (tick or event): 1 if 9-bit sum > 255, else 0; it otherwise holds its value.
REQ-018 spike_cnt SHALL increment on each event, wrapping modulo 256.
REQ-019 I_syn SHALL never underflow; tau_sel = 0 with a tick clears I_syn to 0.
REQ-020 ena low SHALL freeze the prescaler, I_syn, sat and spike_cnt; events arriving while ena is low SHALL be discarded.

Reset
REQ-021 rst_n low at a clock edge SHALL set I_syn=0, sat=0, spike_cnt=0, prescaler=0, spike_q=0, overriding any event or tick in that cycle.
REQ-022 Reset asserted mid-decay SHALL discard partial prescaler progress; the first tick after release occurs DECAY_DIV enabled cycles later.

Configuration
REQ-023 Macro SYN_INHIBIT_EN defined: adds input ports inh_in (1) and inh_weight (8); an inh_in rising edge, detected as in REQ-011, subtracts inh_weight after the REQ-015 sum, floored at 0; an inhibitory event does not change spike_cnt or set sat.
REQ-024 SYN_INHIBIT_EN undefined: the inh_in and inh_weight ports SHALL be absent and behaviour SHALL be exactly REQ-011..REQ-022.

Verification (DECAY_DIV=4, ena=1 unless stated)
REQ-025 rst_n low 2 cycles with spike_in toggling -> I_syn=0, sat=0, spike_cnt=0 on release.
REQ-026 weight=40, tau_sel=2, single 1-cycle spike -> I_syn 40, then 30, 23, 18 on successive ticks; spike_cnt=1.
REQ-027 spike_in held high 10 cycles, weight=5 -> I_syn rises by 5 once; spike_cnt=1.
REQ-028 weight=200, two spikes without an intervening tick -> I_syn 200 then 255, sat=1; next tick with tau_sel=7 -> I_syn=254, sat=0.
REQ-029 I_syn=100, tau_sel=1, event coinciding with tick, weight=10 -> I_syn=60; ena low for 8 cycles with spikes -> I_syn, spike_cnt unchanged.
REQ-030 SYN_INHIBIT_EN: I_syn=30, inh_weight=50 inhibitory event -> I_syn=0; same run without the macro -> ports absent, REQ-026 passes.
